mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LAT, default 5: cycles from first MEMEN-high cycle to R pulse, inclusive; legal range 2..7.
REQ-002 Parameter AW, default 9: word-address bits; array holds 2^AW 16-bit words.
REQ-003 Parameter INIT_FILE, default "": hex preload file; empty means no preload.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 MEMEN  in  1  access request from control; held high until R is seen.
REQ-007 RW  in  1  1 = write, 0 = read.
REQ-008 DATASIZE  in  1  1 = word, 0 = byte (writes only).
REQ-009 MAR  in  16  byte address.
REQ-010 MDR_in  in  16  write data.
REQ-011 MDR_out  out  16  read data.
REQ-012 R  out  1  ready; one-cycle pulse marking completion.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 IDLE->BUSY when MEMEN=1 at a rising edge; MAR, RW, DATASIZE and MDR_in SHALL be captured at that edge; later changes are ignored for that access.
REQ-015 Cycle numbering: the cycle in which MEMEN is first high is cycle 1; R SHALL be high during cycle LAT only.
REQ-016 BUSY->DONE at the edge starting cycle LAT; R is registered and asserted in DONE.
REQ-017 DONE->IDLE unconditionally at the next edge; R is never high for two consecutive cycles.
REQ-018 MEMEN high while in IDLE after DONE SHALL start a new access; back-to-back accesses are legal.
REQ-019 MEMEN low in any BUSY cycle SHALL abort: return to IDLE, no write, no R pulse, MDR_out unchanged.
REQ-020 Word index = MAR[AW:1]; MAR[15:AW+1] ignored (aliasing); MAR[0] ignored for word accesses.
REQ-021 Word write: both bytes written from captured MDR_in.
REQ-022 Byte write: lane MAR[0] only (0 = low, 1 = high), data from the matching lane of MDR_in; the other byte is preserved.
REQ-023 Writes commit at the edge that enters DONE; a read starting in the cycle after R SHALL return the new data.
REQ-024 Read: MDR_out SHALL present the full aligned word in cycle LAT (with R) and hold it until the next completed read.
REQ-025 Write: MDR_out SHALL be unchanged.
REQ-026 The up-counter SHALL be 3 bits wide, cleared on entry to BUSY, with no wrap within a legal LAT.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, R=0, MDR_out=16'h0000 and counter 0.
REQ-028 Reset mid-access SHALL abort with no write and no R pulse.
REQ-029 Array contents SHALL NOT be cleared by reset; at time zero they come from INIT_FILE if given, otherwise undefined.

Structure
REQ-030 Shared package mem_pkg SHALL hold: the state encoding, the DATASIZE encodings (SIZE_BYTE=0, SIZE_WORD=1) and the LAT default.
REQ-031 Storage SHALL be a sub-module mem_array: synchronous write with 2-bit byte enable, combinational read, parameters AW and INIT_FILE.
REQ-032 The FSM, counter and capture registers SHALL live in mem_responder.

Verification
REQ-033 Reset, then word write MAR=16'h0010, MDR_in=16'hBEEF, MEMEN held -> R high only in cycle 5; then read 16'h0010 -> MDR_out=16'hBEEF with R in cycle 5.
REQ-034 Word 16'h0020=16'h1234; byte write MAR=16'h0021, MDR_in=16'h5656 -> read of 16'h0020 returns 16'h5634.
REQ-035 MEMEN dropped in cycle 3 of a write to 16'h0030 (prior value 16'h0000) -> no R pulse; later read returns 16'h0000.
REQ-036 Reset asserted in cycle 4 of a read -> R=0 and MDR_out=0 at once; R stays low until a new access.
REQ-037 Back-to-back: write 16'hA5A5 to 16'h0040, MEMEN kept high into the next access as a read of the same address -> second R 5 cycles after the first DONE cycle, with MDR_out=16'hA5A5.
REQ-038 Alias: write 16'h7777 to MAR=16'h0402 with AW=9 -> read of 16'h0002 returns 16'h7777.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, access-size
// encodings, default latency and a byte-enable helper.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SIZE_BYTE   = 1'b0;
    localparam logic SIZE_WORD   = 1'b1;
    localparam int   LAT_DEFAULT = 5;

    // Byte writes touch only the lane picked by the byte-address LSB.
    function automatic logic [1:0] byte_enable(input logic size, input logic lane);
        logic [1:0] be;
        if (size == SIZE_WORD) begin
            be = 2'b11;
        end else if (lane) begin
            be = 2'b10;
        end else begin
            be = 2'b01;
        end
        return be;
    endfunction

endpackage

// File: rtl/mem_array.sv
// 2^AW x 16-bit storage: synchronous byte-enabled write, combinational read.
// Contents are untouched by reset.
module mem_array #(
    parameter int    AW        = 9,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we && be[0]) begin
            mem[addr][7:0] <= wdata[7:0];
        end
        if (we && be[1]) begin
            mem[addr][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: captures a request, counts LAT cycles, then
// commits the write or loads the read word and pulses R for one cycle.
module mem_responder
    import mem_pkg::*;
#(
    parameter int    LAT       = LAT_DEFAULT,
    parameter int    AW        = 9,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEMEN,
    input  logic        RW,
    input  logic        DATASIZE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_in,
    output logic [15:0] MDR_out,
    output logic        R
);

    // BUSY starts in cycle 2 with the counter at 0, so DONE follows count LAT-3.
    localparam logic [2:0] CNT_LAST = 3'(LAT - 3);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        size_q, size_d;
    logic        r_q, r_d;
    logic [15:0] mdr_out_q, mdr_out_d;

    logic        start;
    logic        commit;
    logic [15:0] acc_mar;
    logic [15:0] acc_wdata;
    logic        acc_rw;
    logic        acc_size;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_rdata;

    assign start = (state_q == ST_IDLE) && MEMEN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mar_q     <= 16'h0000;
            wdata_q   <= 16'h0000;
            rw_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            r_q       <= 1'b0;
            mdr_out_q <= 16'h0000;
        end else begin
            mar_q     <= mar_d;
            wdata_q   <= wdata_d;
            rw_q      <= rw_d;
            size_q    <= size_d;
            r_q       <= r_d;
            mdr_out_q <= mdr_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (MEMEN) begin
                    cnt_d   = 3'd0;
                    state_d = (LAT == 2) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!MEMEN) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Live inputs are used only when the access completes straight from IDLE (LAT=2).
    always_comb begin
        mar_d     = start ? MAR      : mar_q;
        wdata_d   = start ? MDR_in   : wdata_q;
        rw_d      = start ? RW       : rw_q;
        size_d    = start ? DATASIZE : size_q;
        acc_mar   = mar_d;
        acc_wdata = wdata_d;
        acc_rw    = rw_d;
        acc_size  = size_d;
    end

    always_comb begin
        commit    = (state_d == ST_DONE);
        mem_we    = commit && acc_rw;
        mem_be    = byte_enable(acc_size, acc_mar[0]);
        r_d       = commit;
        mdr_out_d = (commit && !acc_rw) ? mem_rdata : mdr_out_q;
    end

    mem_array #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .addr  (acc_mar[AW:1]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    generate
        if (AW < 15) begin : g_alias
            logic unused_alias_bits;
            assign unused_alias_bits = ^acc_mar[15:AW+1];
        end
    endgenerate

    assign R       = r_q;
    assign MDR_out = mdr_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a word-array model predicts R timing and
// read data from the access rules; directed cases cover reset, abort and aliasing.
module tb_mem_responder;

    localparam int LAT   = 5;
    localparam int AW    = 9;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        reset;
    logic        memen;
    logic        rw;
    logic        datasize;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mdr_out;
    logic        r;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_mem [DEPTH];
    logic [15:0] mdr_exp;
    int          pool [8];

    mem_responder #(
        .LAT       (LAT),
        .AW        (AW),
        .INIT_FILE ("")
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MEMEN    (memen),
        .RW       (rw),
        .DATASIZE (datasize),
        .MAR      (mar),
        .MDR_in   (mdr_in),
        .MDR_out  (mdr_out),
        .R        (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int word_index(input logic [15:0] a);
        return (int'(a) / 2) % DEPTH;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One access, started just after a rising edge; drop_at>0 releases MEMEN in that cycle.
    task automatic applyStimulus(input logic wr, input logic size, input logic [15:0] addr,
                                 input logic [15:0] data, input int drop_at, input bit keep_high);
        int last;
        int idx;
        bit aborted;
        idx     = word_index(addr);
        last    = (drop_at > 0) ? LAT + 1 : LAT;
        aborted = 1'b0;
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (cyc == 1) begin
                memen = 1'b1; rw = wr; datasize = size; mar = addr; mdr_in = data;
            end else if (cyc == drop_at) begin
                memen = 1'b0; aborted = 1'b1;
            end else if (cyc == LAT && !aborted) begin
                memen = keep_high;
            end else if (!aborted) begin
                rw = 1'($urandom); datasize = 1'($urandom);
                mar = 16'($urandom); mdr_in = 16'($urandom);
            end
            if (cyc == LAT && !aborted && !wr) begin
                mdr_exp = model_mem[idx];
            end
            @(negedge clk);
            checkOutput("r_pulse", {15'd0, r}, {15'd0, 1'(cyc == LAT && !aborted)});
            if (wr) begin
                checkOutput("mdr_hold", mdr_out, mdr_exp);
            end else begin
                checkOutput("mdr_read", mdr_out, mdr_exp);
            end
            @(posedge clk);
            #1;
        end
        if (wr && !aborted) begin
            if (size) begin
                model_mem[idx] = data;
            end else if (int'(addr) % 2 == 1) begin
                model_mem[idx][15:8] = data[15:8];
            end else begin
                model_mem[idx][7:0] = data[7:0];
            end
        end
    endtask

    initial begin
        int p;
        int hi;
        int lsb;
        int drop;
        bit keep;
        logic [15:0] addr;

        reset = 1'b0; memen = 1'b0; rw = 1'b0; datasize = 1'b1;
        mar = 16'h0000; mdr_in = 16'h0000; mdr_exp = 16'h0000;
        #1 reset = 1'b1;
        #1;
        checkOutput("reset_r", {15'd0, r}, 16'h0000);
        checkOutput("reset_mdr", mdr_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0000, 0, 1'b0);
        checkOutput("beef_read", mdr_out, 16'hBEEF);

        memen = 1'b1; rw = 1'b0; datasize = 1'b1; mar = 16'h0010; mdr_in = 16'h0000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        checkOutput("mdr_before_reset", mdr_out, 16'hBEEF);
        reset = 1'b1;
        memen = 1'b0;
        #1;
        checkOutput("midreset_r", {15'd0, r}, 16'h0000);
        checkOutput("midreset_mdr", mdr_out, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        mdr_exp = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_reset_r", {15'd0, r}, 16'h0000);
            checkOutput("post_reset_mdr", mdr_out, 16'h0000);
        end
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0021, 16'h5656, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h0000, 0, 1'b0);
        checkOutput("byte_merge", mdr_out, 16'h5634);

        applyStimulus(1'b1, 1'b1, 16'h0030, 16'h0000, 0, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0030, 16'hDEAD, 3, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0030, 16'h0000, 0, 1'b0);
        checkOutput("abort_no_write", mdr_out, 16'h0000);

        applyStimulus(1'b1, 1'b1, 16'h0040, 16'hA5A5, 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 1'b0);
        checkOutput("back_to_back", mdr_out, 16'hA5A5);

        applyStimulus(1'b1, 1'b1, 16'h0402, 16'h7777, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 16'h0002, 16'h0000, 0, 1'b0);
        checkOutput("alias_read", mdr_out, 16'h7777);

        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(DEPTH - 1, 0);
            applyStimulus(1'b1, 1'b1, 16'(pool[i] * 2), 16'($urandom), 0, 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            p    = pool[$urandom_range(7, 0)];
            hi   = $urandom_range(63, 0);
            lsb  = $urandom_range(1, 0);
            addr = 16'((hi << 10) | (p << 1) | lsb);
            drop = ($urandom_range(5, 0) == 0) ? $urandom_range(LAT - 1, 2) : 0;
            keep = (n < 39) && ($urandom_range(1, 0) == 1);
            applyStimulus(1'($urandom), 1'($urandom), addr, 16'($urandom), drop, keep);
        end
        memen = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
